// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// geometry constants, FSM state encoding and block byte helpers.
package dcache_responder_pkg;

    localparam int DC_ADDR_W   = 8;
    localparam int DC_INDEX_W  = 3;
    localparam int DC_OFFSET_W = 2;
    localparam int DC_TAG_W    = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } dc_state_t;

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] blk_byte(input logic [31:0] blk, input logic [1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] blk_merge(input logic [31:0] blk, input logic [1:0] off,
                                              input logic [7:0] b);
        logic [31:0] r;
        r = blk;
        r[{off, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU-side byte interface and memory-side block interface of the data cache.
// The CPU / cache / memory each take the master or slave view as appropriate.
interface dcache_cpu_if #(parameter int ADDR_W = 8);
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [7:0]        WRITEDATA;
    logic [7:0]        READDATA;
    logic              BUSYWAIT;

    modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
    modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if #(parameter int BLK_ADDR_W = 6);
    logic                  mem_read;
    logic                  mem_write;
    logic [BLK_ADDR_W-1:0] mem_address;
    logic [31:0]           mem_writedata;
    logic [31:0]           mem_readdata;
    logic                  mem_busywait;

    modport master (output mem_read, mem_write, mem_address, mem_writedata,
                    input mem_readdata, mem_busywait);
    modport slave  (input mem_read, mem_write, mem_address, mem_writedata,
                    output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_responder_fsm.sv
// Miss-handling sequencer of the data cache: state register, next-state
// logic and the registered mem_read / mem_write decodes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or FILL
//   WRITEBACK | push victim block to memory until mem_busywait drops
//   FILL      | fetch requested block; install it when mem_busywait drops
module dcache_fsm
    import dcache_responder_pkg::*;
(
    input  logic      CLK,
    input  logic      RESET,
    input  logic      req,
    input  logic      hit,
    input  logic      victim_dirty,
    input  logic      mem_busywait,
    output dc_state_t state_q,
    output logic      fill_done,
    output logic      mem_read,
    output logic      mem_write
);

    dc_state_t state_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_read  <= (state_d == FILL);
            mem_write <= (state_d == WRITEBACK);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !hit)
                    state_d = victim_dirty ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                if (!mem_busywait)
                    state_d = FILL;
            end
            FILL: begin
                if (!mem_busywait)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill_done = (state_q == FILL) && !mem_busywait;

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU byte
// port and the 32-bit block data memory. Arrays and hit logic live here.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int ADDR_W   = DC_ADDR_W,
    parameter int INDEX_W  = DC_INDEX_W,
    parameter int OFFSET_W = DC_OFFSET_W
)(
    input logic          CLK,
    input logic          RESET,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;

    logic [31:0]       data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_idx_q;

    logic      req;
    logic      hit;
    logic      wr_hit;
    logic      miss_start;
    logic      fill_done;
    logic      mem_read;
    logic      mem_write;
    dc_state_t state;

    assign req_tag = cpu.ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_idx = cpu.ADDRESS[OFFSET_W +: INDEX_W];
    assign req_off = cpu.ADDRESS[OFFSET_W-1:0];

    assign req        = cpu.READ | cpu.WRITE;
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign wr_hit     = (state == IDLE) && cpu.WRITE && hit;
    assign miss_start = (state == IDLE) && req && !hit;

    dcache_fsm u_fsm (
        .CLK          (CLK),
        .RESET        (RESET),
        .req          (req),
        .hit          (hit),
        .victim_dirty (valid_q[req_idx] && dirty_q[req_idx]),
        .mem_busywait (mem.mem_busywait),
        .state_q      (state),
        .fill_done    (fill_done),
        .mem_read     (mem_read),
        .mem_write    (mem_write)
    );

    // Valid/dirty are the only reset state; a reset mid-miss leaves every line invalid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
        end else if (wr_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    // The miss block is latched so the fill still installs where it was
    // requested even if the CPU drops its request mid-sequence.
    always_ff @(posedge CLK) begin
        if (miss_start) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
        end
        if (fill_done) begin
            data_q[miss_idx_q] <= mem.mem_readdata;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (wr_hit) begin
            data_q[req_idx] <= blk_merge(data_q[req_idx], req_off, cpu.WRITEDATA);
        end
    end

    assign cpu.BUSYWAIT = req && !((state == IDLE) && hit);
    assign cpu.READDATA = (cpu.READ && hit) ? blk_byte(data_q[req_idx], req_off) : 8'h00;

    assign mem.mem_read      = mem_read;
    assign mem.mem_write     = mem_write;
    assign mem.mem_address   = (state == WRITEBACK) ? {tag_q[miss_idx_q], miss_idx_q}
                                                    : {miss_tag_q, miss_idx_q};
    assign mem.mem_writedata = data_q[miss_idx_q];

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a 5-cycle-busywait block memory model.
module tb_dcache_responder;

    logic CLK = 1'b0;
    logic RESET;

    dcache_cpu_if cpu ();
    dcache_mem_if mem ();

    dcache_responder dut (
        .CLK   (CLK),
        .RESET (RESET),
        .cpu   (cpu),
        .mem   (mem)
    );

    always #5 CLK = ~CLK;

    // Block memory: busywait for 5 cycles per request, data/ack in the 6th.
    logic [31:0] mem_blk [64];
    bit          mem_loaded = 1'b0;
    logic [1:0]  mreq;
    logic [1:0]  mreq_prev;
    int          mcnt;

    assign mreq = {mem.mem_read, mem.mem_write};
    assign mem.mem_busywait = (mreq != 2'b00) && ((mreq != mreq_prev) || (mcnt < 5));
    assign mem.mem_readdata = mem_blk[mem.mem_address];

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mreq_prev <= 2'b00;
            mcnt      <= 0;
        end else begin
            if (mreq != 2'b00)
                mcnt <= (mreq == mreq_prev) ? mcnt + 1 : 1;
            else
                mcnt <= 0;
            mreq_prev <= mreq;
        end
    end

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem_blk[i] <= 32'h0;
            mem_blk[6'h01] <= 32'hDDCCBBAA;
            mem_blk[6'h09] <= 32'h0D0C0B0A;
            mem_blk[6'h20] <= 32'h99887766;
            mem_blk[6'h3F] <= 32'h44332211;
            mem_loaded     <= 1'b1;
        end else if (mem.mem_write && !mem.mem_busywait) begin
            mem_blk[mem.mem_address] <= mem.mem_writedata;
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        cpu.READ      = rd;
        cpu.WRITE     = wr;
        cpu.ADDRESS   = a;
        cpu.WRITEDATA = d;
        #1;
    endtask

    // Results of the last stalled request
    int          r_cycles;
    logic        r_wb, r_fill, r_both;
    logic [5:0]  r_wb_addr, r_fill_addr;
    logic [31:0] r_wb_data;

    task automatic run_req();
        r_cycles = 0; r_wb = 0; r_fill = 0; r_both = 0;
        r_wb_addr = '0; r_fill_addr = '0; r_wb_data = '0;
        while (cpu.BUSYWAIT && r_cycles < 40) begin
            step();
            r_cycles++;
            if (mem.mem_read && mem.mem_write) r_both = 1;
            if (mem.mem_write && !r_wb) begin
                r_wb = 1; r_wb_addr = mem.mem_address; r_wb_data = mem.mem_writedata;
            end
            if (mem.mem_read && !r_fill) begin
                r_fill = 1; r_fill_addr = mem.mem_address;
            end
        end
        chk("stall_bounded", cpu.BUSYWAIT, 1'b0);
        chk("rd_wr_exclusive", r_both, 1'b0);
    endtask

    initial begin
        RESET = 1'b0;
        cpu_drive(0, 0, 8'h00, 8'h00);
        repeat (2) step();
        chk("rst_busywait", cpu.BUSYWAIT, 1'b0);
        chk("rst_readdata", cpu.READDATA, 8'h00);
        chk("rst_mem_rd_wr", {mem.mem_read, mem.mem_write}, 2'b00);
        RESET = 1'b1;
        step();

        // clean read miss
        cpu_drive(1, 0, 8'h04, 8'h00);
        chk("miss04_busy", cpu.BUSYWAIT, 1'b1);
        run_req();
        chk("miss04_cycles", r_cycles, 7);
        chk("miss04_no_wb", r_wb, 1'b0);
        chk("miss04_fill_addr", r_fill_addr, 6'h01);
        chk("miss04_data", cpu.READDATA, 8'hAA);
        step();
        chk("miss04_mem_idle", {mem.mem_read, mem.mem_write}, 2'b00);

        // write hit then read back
        cpu_drive(0, 1, 8'h05, 8'h55);
        chk("wr05_busy", cpu.BUSYWAIT, 1'b0);
        step();
        chk("wr05_mem_idle", {mem.mem_read, mem.mem_write}, 2'b00);
        cpu_drive(1, 0, 8'h05, 8'h00);
        chk("rd05_busy", cpu.BUSYWAIT, 1'b0);
        chk("rd05_data", cpu.READDATA, 8'h55);
        step();

        // write miss with dirty victim
        cpu_drive(0, 1, 8'h24, 8'h77);
        chk("wr24_busy", cpu.BUSYWAIT, 1'b1);
        run_req();
        chk("wr24_cycles", r_cycles, 13);
        chk("wr24_wb_seen", r_wb, 1'b1);
        chk("wr24_wb_addr", r_wb_addr, 6'h01);
        chk("wr24_wb_data", r_wb_data, 32'hDDCC55AA);
        chk("wr24_fill_addr", r_fill_addr, 6'h09);
        chk("wr24_mem_blk1", mem_blk[6'h01], 32'hDDCC55AA);
        step();
        cpu_drive(1, 0, 8'h24, 8'h00);
        chk("rd24_data", cpu.READDATA, 8'h77);
        chk("rd24_busy", cpu.BUSYWAIT, 1'b0);
        step();
        cpu_drive(1, 0, 8'h25, 8'h00);
        chk("rd25_data", cpu.READDATA, 8'h0B);
        step();

        // read miss evicts the line just written: proves it was left dirty
        cpu_drive(1, 0, 8'h04, 8'h00);
        run_req();
        chk("re04_cycles", r_cycles, 13);
        chk("re04_wb_addr", r_wb_addr, 6'h09);
        chk("re04_wb_data", r_wb_data, 32'h0D0C0B77);
        chk("re04_fill_addr", r_fill_addr, 6'h01);
        chk("re04_data", cpu.READDATA, 8'hAA);
        step();

        // back-to-back read hits
        cpu_drive(1, 0, 8'h04, 8'h00);
        chk("b2b04_busy", cpu.BUSYWAIT, 1'b0);
        chk("b2b04_data", cpu.READDATA, 8'hAA);
        step();
        cpu_drive(1, 0, 8'h06, 8'h00);
        chk("b2b06_busy", cpu.BUSYWAIT, 1'b0);
        chk("b2b06_data", cpu.READDATA, 8'hCC);
        step();
        cpu_drive(1, 0, 8'h05, 8'h00);
        chk("b2b05_busy", cpu.BUSYWAIT, 1'b0);
        chk("b2b05_data", cpu.READDATA, 8'h55);
        step();

        // index wrap at 8'hFF
        cpu_drive(1, 0, 8'hFF, 8'h00);
        run_req();
        chk("rdFF_cycles", r_cycles, 7);
        chk("rdFF_no_wb", r_wb, 1'b0);
        chk("rdFF_fill_addr", r_fill_addr, 6'h3F);
        chk("rdFF_data", cpu.READDATA, 8'h44);
        step();

        // reset mid-fill
        cpu_drive(1, 0, 8'h80, 8'h00);
        repeat (3) step();
        chk("mid_fill_mem_read", mem.mem_read, 1'b1);
        RESET = 1'b0;
        #1;
        chk("rst_async_mem_read", mem.mem_read, 1'b0);
        cpu_drive(0, 0, 8'h80, 8'h00);
        chk("rst_noreq_busy", cpu.BUSYWAIT, 1'b0);
        chk("rst_noreq_data", cpu.READDATA, 8'h00);
        step();
        RESET = 1'b1;
        step();
        cpu_drive(1, 0, 8'hFF, 8'h00);
        chk("post_rst_FF_miss", cpu.BUSYWAIT, 1'b1);
        cpu_drive(0, 0, 8'h00, 8'h00);
        step();
        cpu_drive(1, 0, 8'h80, 8'h00);
        chk("post_rst_80_miss", cpu.BUSYWAIT, 1'b1);
        run_req();
        chk("re80_cycles", r_cycles, 7);
        chk("re80_fill_addr", r_fill_addr, 6'h20);
        chk("re80_data", cpu.READDATA, 8'h66);
        step();
        cpu_drive(0, 0, 8'h00, 8'h00);
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Acts as the responder to the CPU's byte-wide READ/WRITE/ADDRESS/BUSYWAIT memory interface.
- Acts as initiator toward data memory on a 32-bit block interface.
- Inserted between the cpu and data_memory in the CPU testbench; same CPU-side handshake as the existing memory, so the cpu is unchanged.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- INDEX_W, 3, set-index bits (8 lines).
- OFFSET_W, 2, byte-offset bits (4-byte blocks, fixed).
- TAG_W = ADDR_W-INDEX_W-OFFSET_W = 3 (derived, not overridable).

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU read request.
- WRITE  in  1  CPU write request (READ and WRITE never both high).
- ADDRESS  in  8  CPU byte address {tag[7:5], index[4:2], offset[1:0]}.
- WRITEDATA  in  8  CPU write byte.
- READDATA  out  8  CPU read byte.
- BUSYWAIT  out  1  stall to CPU.
- mem_read  out  1  block read request.
- mem_write  out  1  block write-back request.
- mem_address  out  6  block address {tag,index}.
- mem_writedata  out  32  victim block; byte0 = bits[7:0].
- mem_readdata  in  32  fill block.
- mem_busywait  in  1  memory stall.

Behaviour:
- Reset (RESET=0, async): all valid and dirty bits cleared; state=IDLE; mem_read=mem_write=0; BUSYWAIT=0; READDATA=8'h00. Data and tag arrays are not reset.
- hit = valid[index] && tag[index]==ADDRESS[7:5]; combinational.
- BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit); combinational.
- READDATA = selected byte of line[index] when READ && hit, else 8'h00.
- States: IDLE, WRITEBACK, FILL.
- IDLE, read hit: zero-wait; BUSYWAIT low in the request cycle; the CPU samples READDATA at the next posedge.
- IDLE, write hit: byte written at posedge; dirty[index]=1; BUSYWAIT low.
- IDLE, miss with dirty victim: go to WRITEBACK at posedge.
- IDLE, miss with clean or invalid victim: go to FILL at posedge.
- WRITEBACK: mem_write=1; mem_address={stored tag,index}; mem_writedata=line[index]. At the first posedge with mem_busywait=0, go to FILL.
- FILL: mem_read=1; mem_address={ADDRESS tag,index}. At the first posedge with mem_busywait=0: line=mem_readdata, tag written, valid=1, dirty=0, go to IDLE.
- After a fill, the request hits in IDLE; a write miss completes as a write hit one cycle after the fill.
- mem_read/mem_write are registered state decodes, high for the whole state, and deasserted on the posedge that leaves the state.
- Miss latency, clean: 1 (IDLE→FILL) + memory cycles + 1 (hit cycle).
- Miss latency, dirty: adds WRITEBACK time on top of the clean-miss latency.
- The CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1.
- If the CPU request drops during WRITEBACK/FILL, the sequence still completes and the line is installed; no CPU data is written.
- Reset mid-WRITEBACK/FILL aborts immediately: requests drop, all lines invalid, and the partial block is lost.
- mem_busywait high in IDLE is ignored.
- Index wrap: ADDRESS 8'hFF maps to index 7, offset 3; no special case.

Decomposition:
- Shared package/header dcache_defs holds:
  - the state encoding (IDLE=2'd0, WRITEBACK=2'd1, FILL=2'd2);
  - the TAG_W/INDEX_W/OFFSET_W constants;
  - the field-slice macros.
- One sub-module: dcache_fsm (state register, next-state logic, mem_read/mem_write decode).
- Arrays and hit logic stay in the top module.

Test Plan:
- Reset then READ 8'h04: clean miss. FILL with mem_address=6'h01, then READDATA = byte0 of the fill word (fill 32'hDDCCBBAA → 8'hAA). BUSYWAIT low 1 cycle after mem_busywait falls; the bench memory model has a 5-cycle busywait.
- WRITE 8'h55 to 8'h05 after the previous fill: write hit, BUSYWAIT never high, no mem_* activity. Then READ 8'h05 → 8'h55 with zero wait.
- WRITE 8'h24 (same index 1, tag 1) with line 1 dirty:
  - WRITEBACK with mem_address=6'h01, mem_writedata=32'hDDCC55AA;
  - then FILL with mem_address=6'h09;
  - finally the byte is written with dirty=1.
- READ 8'hFF cold: FILL with mem_address=6'h3F; READDATA = mem_readdata[31:24].
- Assert RESET=0 mid-FILL: mem_read drops asynchronously, BUSYWAIT=0 when no request is present, and a re-read of the same address misses again.
- Back-to-back read hits on 8'h04 and 8'h06: one result per cycle, and BUSYWAIT stays 0 throughout.
